// File: rtl/teclado_matricial_scanner.sv
// 4x4 matrix keypad scanner: one-hot active-low row drive, synchronized column sampling,
// and a debounce FSM that emits one key_valid pulse per accepted press.
module teclado_matricial_scanner #(
  parameter int ROW_CYCLES     = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] matricial_col,
  output logic [3:0] matricial_lin,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int PW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

  logic [3:0]    col_s1, col_s2;
  logic [1:0]    row_idx;
  logic [PW-1:0] phase;
  logic [11:0]   hits;
  logic [15:0]   scan_hits;
  logic [4:0]    hit_count;
  logic [3:0]    hit_idx;
  logic          scan_end, scan_none, scan_single;
  logic [3:0]    scan_code;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    cand, cand_n;
  logic          accept;

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:  key_map = 4'h1;  4'd1:  key_map = 4'h2;  4'd2:  key_map = 4'h3;  4'd3:  key_map = 4'hA;
      4'd4:  key_map = 4'h4;  4'd5:  key_map = 4'h5;  4'd6:  key_map = 4'h6;  4'd7:  key_map = 4'hB;
      4'd8:  key_map = 4'h7;  4'd9:  key_map = 4'h8;  4'd10: key_map = 4'h9;  4'd11: key_map = 4'hC;
      4'd12: key_map = 4'hE;  4'd13: key_map = 4'h0;  4'd14: key_map = 4'hF;  default: key_map = 4'hD;
    endcase
  endfunction

  // Column synchronizer, row/phase sequencer and per-row hit capture for rows 0-2.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      col_s1  <= 4'hF;
      col_s2  <= 4'hF;
      row_idx <= '0;
      phase   <= '0;
      hits    <= '0;
    end else begin
      col_s1 <= matricial_col;
      col_s2 <= col_s1;
      if (phase == LAST_PHASE) begin
        phase   <= '0;
        row_idx <= row_idx + 2'd1;
        case (row_idx)
          2'd0:    hits[3:0]  <= ~col_s2;
          2'd1:    hits[7:4]  <= ~col_s2;
          2'd2:    hits[11:8] <= ~col_s2;
          default: ;
        endcase
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

  // Row 3 is taken straight from the synchronizer at the scan-end clock.
  assign scan_end  = (row_idx == 2'd3) && (phase == LAST_PHASE);
  assign scan_hits = {~col_s2, hits};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    hit_count = '0;
    hit_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_hits[i]) begin
        hit_count = hit_count + 5'd1;
        hit_idx   = 4'(i);
      end
    end
  end

  assign scan_none   = (hit_count == 5'd0);
  assign scan_single = (hit_count == 5'd1);
  assign scan_code   = key_map(hit_idx);

  // State register plus the registered key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_valid <= accept;
      if (accept) key_code <= cand_n;
    end
  end

  // Next-state logic; the FSM only moves on scan-end clocks.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (scan_single) begin
            cand_n = scan_code;
            cnt_n  = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_n = PRESSED;
            end else begin
              state_n = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (scan_single) begin
            if (scan_code == cand) begin
              cnt_n = cnt + CW'(1);
            end else begin
              cand_n = scan_code;
              cnt_n  = CW'(1);
            end
            if (cnt_n == DEB_TARGET) begin
              accept  = 1'b1;
              state_n = PRESSED;
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        PRESSED: begin
          if (scan_none) begin
            cnt_n   = CW'(1);
            state_n = (DEBOUNCE_SCANS == 1) ? IDLE : DEB_REL;
          end
        end
        default: begin
          if (scan_none) begin
            cnt_n = cnt + CW'(1);
            if (cnt_n == DEB_TARGET) state_n = IDLE;
          end else begin
            state_n = PRESSED;
          end
        end
      endcase
    end
  end

  // Outputs decoded from state and row index.
  always_comb begin
    matricial_lin = ~(4'b0001 << row_idx);
    key_held      = (state == PRESSED) || (state == DEB_REL);
  end

endmodule
